// File: rtl/vga_timing_pkg.sv
// SVGA 800x600@72 raster timing constants and the control bundle carried
// down the video alignment delay line.
package vga_timing_pkg;

  localparam int CW = 12;

  localparam int HSIZE = 800;
  localparam int HFP   = 856;
  localparam int HSP   = 976;
  localparam int HMAX  = 1040;
  localparam int VSIZE = 600;
  localparam int VFP   = 637;
  localparam int VSP   = 643;
  localparam int VMAX  = 666;

  localparam logic HSPP = 1'b1;
  localparam logic VSPP = 1'b1;

  localparam int PIX_LAT = 1;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic fs;
  } video_ctl_t;

  // Half-open window test lo <= cnt < hi.
  function automatic logic in_span(input logic [CW-1:0] cnt,
                                   input logic [CW-1:0] lo,
                                   input logic [CW-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_ctl_delay.sv
// Fixed-depth shift register of video control bits; exposes one intermediate
// tap so the pixel register can be gated in step with the final stage.
module ctl_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAP   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  video_ctl_t rst_val_i,
  input  video_ctl_t din_i,
  output video_ctl_t tap_o,
  output video_ctl_t dout_o
);

  video_ctl_t [DEPTH-1:0] stage_q;
  video_ctl_t [DEPTH-1:0] stage_d;

  // Shift one stage per clock, newest sample entering at index 0.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = din_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Every stage holds the inactive bundle while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= {DEPTH{rst_val_i}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tap_o  = stage_q[TAP];
  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// Free-running raster scan: issues read coordinates to the frame-buffer reader
// and re-aligns the returned pixel with de/hsync/vsync/frame_start at the pins.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   HSIZE   = vga_timing_pkg::HSIZE,
  parameter int   HFP     = vga_timing_pkg::HFP,
  parameter int   HSP     = vga_timing_pkg::HSP,
  parameter int   HMAX    = vga_timing_pkg::HMAX,
  parameter int   VSIZE   = vga_timing_pkg::VSIZE,
  parameter int   VFP     = vga_timing_pkg::VFP,
  parameter int   VSP     = vga_timing_pkg::VSP,
  parameter int   VMAX    = vga_timing_pkg::VMAX,
  parameter logic HSPP    = vga_timing_pkg::HSPP,
  parameter logic VSPP    = vga_timing_pkg::VSPP,
  parameter int   PIX_LAT = vga_timing_pkg::PIX_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] read_x,
  output logic [11:0] read_y,
  input  logic [23:0] pixel_data,
  output logic [7:0]  video_red,
  output logic [7:0]  video_green,
  output logic [7:0]  video_blue,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic        video_de,
  output logic        frame_start
);

  localparam logic [11:0] H_LAST = 12'(HMAX - 1);
  localparam logic [11:0] V_LAST = 12'(VMAX - 1);

  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  logic [23:0] rgb_q, rgb_d;

  video_ctl_t raw_s;
  video_ctl_t rst_ctl_s;
  video_ctl_t tap_s;
  video_ctl_t out_s;

  // Horizontal counter wraps each line; vertical advances on the line wrap.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = 12'd0;
      if (vcnt_q == V_LAST) begin
        vcnt_d = 12'd0;
      end else begin
        vcnt_d = vcnt_q + 12'd1;
      end
    end else begin
      hcnt_d = hcnt_q + 12'd1;
    end
  end

  // Scan position registers double as the reader coordinate outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= 12'd0;
      vcnt_q <= 12'd0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Unaligned timing for the coordinate currently being issued.
  always_comb begin
    raw_s.de    = (hcnt_q < 12'(HSIZE)) && (vcnt_q < 12'(VSIZE));
    raw_s.hsync = in_span(hcnt_q, 12'(HFP), 12'(HSP)) ? HSPP : ~HSPP;
    raw_s.vsync = in_span(vcnt_q, 12'(VFP), 12'(VSP)) ? VSPP : ~VSPP;
    raw_s.fs    = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
  end

  assign rst_ctl_s = '{de: 1'b0, hsync: ~HSPP, vsync: ~VSPP, fs: 1'b0};

  ctl_delay #(
    .DEPTH (PIX_LAT + 1),
    .TAP   (PIX_LAT - 1)
  ) u_ctl_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_val_i (rst_ctl_s),
    .din_i     (raw_s),
    .tap_o     (tap_s),
    .dout_o    (out_s)
  );

  // The tap's de belongs to the pixel arriving now, so it blanks RGB.
  always_comb begin
    if (tap_s.de) begin
      rgb_d = pixel_data;
    end else begin
      rgb_d = 24'h000000;
    end
  end

  // Output pixel register, same stage as the final control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= 24'h000000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign read_x      = hcnt_q;
  assign read_y      = vcnt_q;
  assign video_red   = rgb_q[23:16];
  assign video_green = rgb_q[15:8];
  assign video_blue  = rgb_q[7:0];
  assign video_hsync = out_s.hsync;
  assign video_vsync = out_s.vsync;
  assign video_de    = out_s.de;
  assign frame_start = out_s.fs;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl with a shortened vertical frame so that
// wrap-around and frame period fit in a short run.
module tb_vga_scan_ctrl;

  localparam int TB_VSIZE = 12;
  localparam int TB_VFP   = 14;
  localparam int TB_VSP   = 20;
  localparam int TB_VMAX  = 22;
  localparam int LINE     = 1040;
  localparam int FRAME    = LINE * TB_VMAX;
  localparam int LIMIT    = 2 * FRAME;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] read_x, read_y;
  logic [23:0] pixel_data = 24'h000000;
  logic [7:0]  video_red, video_green, video_blue;
  logic        video_hsync, video_vsync, video_de, frame_start;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;
  bit white = 1'b0;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
  } exp_t;

  exp_t sb_q[$];
  exp_t iss_e, mon_e;
  int   ex = 0, ey = 0;
  int   cyc = 0, vs_cycles = 0;
  int   fs1, fs2, hs_n;
  bit   ok;

  vga_scan_ctrl #(
    .VSIZE (TB_VSIZE),
    .VFP   (TB_VFP),
    .VSP   (TB_VSP),
    .VMAX  (TB_VMAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_x      (read_x),
    .read_y      (read_y),
    .pixel_data  (pixel_data),
    .video_red   (video_red),
    .video_green (video_green),
    .video_blue  (video_blue),
    .video_hsync (video_hsync),
    .video_vsync (video_vsync),
    .video_de    (video_de),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Reader model: one clock of latency from coordinate to pixel.
  always @(posedge clk)
    pixel_data <= white ? 24'hFFFFFF : {read_x[7:0], read_y[7:0], 8'hA5};

  always @(posedge clk) begin
    if (rst_n) begin
      cyc <= cyc + 1;
      if (video_vsync) vs_cycles <= vs_cycles + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Issuer: checks the coordinate and queues the expected output for it.
  always @(negedge clk) begin
    if (!run) begin
      ex = 0;
      ey = 0;
    end else begin
      total++;
      if (read_x !== 12'(ex) || read_y !== 12'(ey)) begin
        bad++;
        $display("FAIL coord: got (%0d,%0d) want (%0d,%0d)", read_x, read_y, ex, ey);
      end
      iss_e.x   = ex;
      iss_e.y   = ey;
      iss_e.de  = (ex < 800) && (ey < TB_VSIZE);
      iss_e.rgb = !iss_e.de ? 24'h000000 :
                  white ? 24'hFFFFFF : {8'(ex), 8'(ey), 8'hA5};
      iss_e.hs  = (ex >= 856) && (ex < 976);
      iss_e.vs  = (ey >= TB_VFP) && (ey < TB_VSP);
      iss_e.fs  = (ex == 0) && (ey == 0);
      sb_q.push_back(iss_e);
      if (ex == LINE - 1) begin
        ex = 0;
        ey = (ey == TB_VMAX - 1) ? 0 : ey + 1;
      end else begin
        ex++;
      end
    end
  end

  // Monitor: once the two-clock pipeline is full, every cycle presents a pixel.
  always begin
    @(negedge clk);
    #1;
    if (sb_q.size() > 2) begin
      mon_e = sb_q.pop_front();
      total++;
      if ({video_red, video_green, video_blue} !== mon_e.rgb || video_hsync !== mon_e.hs ||
          video_vsync !== mon_e.vs || video_de !== mon_e.de || frame_start !== mon_e.fs) begin
        bad++;
        $display("FAIL out(%0d,%0d): got rgb=%h hs=%b vs=%b de=%b fs=%b want rgb=%h hs=%b vs=%b de=%b fs=%b",
                 mon_e.x, mon_e.y, {video_red, video_green, video_blue}, video_hsync, video_vsync,
                 video_de, frame_start, mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.de, mon_e.fs);
      end
    end
  end

  task automatic wait_xy(input int x, input int y);
    ok = 1'b0;
    for (int i = 0; i < LIMIT && !ok; i++) begin
      @(negedge clk);
      if (read_x == 12'(x) && read_y == 12'(y)) ok = 1'b1;
    end
    if (!ok) chk($sformatf("timeout_xy_%0d_%0d", x, y), 32'd0, 32'd1);
  endtask

  task automatic wait_fs();
    ok = 1'b0;
    for (int i = 0; i < LIMIT && !ok; i++) begin
      @(negedge clk);
      if (frame_start) ok = 1'b1;
    end
    if (!ok) chk("timeout_fs", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read_x"}, 32'(read_x), 32'd0);
    chk({tag, "_read_y"}, 32'(read_y), 32'd0);
    chk({tag, "_rgb"}, 32'({video_red, video_green, video_blue}), 32'd0);
    chk({tag, "_hsync"}, 32'(video_hsync), 32'd0);
    chk({tag, "_vsync"}, 32'(video_vsync), 32'd0);
    chk({tag, "_de"}, 32'(video_de), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  task automatic release_and_check(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run   = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_read_x_first_edge"}, 32'(read_x), 32'd1);
    chk({tag, "_fs_edge1"}, 32'(frame_start), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_fs_edge2"}, 32'(frame_start), 32'd1);
    fs1 = cyc;
    @(posedge clk);
    #1;
    chk({tag, "_fs_edge3"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    release_and_check("rel");

    wait_xy(5, 3);
    @(negedge clk);
    @(negedge clk);
    chk("pix_5_3_rgb", 32'({video_red, video_green, video_blue}), 32'h0005_03A5);
    chk("pix_5_3_de", 32'(video_de), 32'd1);

    wait_xy(799, 10);
    @(negedge clk);
    @(negedge clk);
    chk("de_799", 32'(video_de), 32'd1);
    @(negedge clk);
    chk("de_800", 32'(video_de), 32'd0);

    wait_xy(856, 10);
    @(negedge clk);
    chk("hs_855", 32'(video_hsync), 32'd0);
    @(negedge clk);
    chk("hs_856", 32'(video_hsync), 32'd1);
    hs_n = 1;
    for (int i = 0; i < 300 && video_hsync; i++) begin
      @(negedge clk);
      if (video_hsync) hs_n++;
    end
    chk("hs_width", 32'(hs_n), 32'd120);

    @(posedge clk);
    #2;
    white = 1'b1;
    wait_xy(100, 11);
    @(negedge clk);
    @(negedge clk);
    chk("white_visible", 32'({video_red, video_green, video_blue}), 32'h00FF_FFFF);
    wait_xy(900, 11);
    @(negedge clk);
    @(negedge clk);
    chk("white_hblank", 32'({video_red, video_green, video_blue}), 32'd0);
    wait_xy(100, 15);
    @(negedge clk);
    @(negedge clk);
    chk("white_vblank", 32'({video_red, video_green, video_blue}), 32'd0);
    chk("white_vblank_de", 32'(video_de), 32'd0);

    wait_xy(1039, TB_VMAX - 1);
    @(posedge clk);
    #1;
    chk("wrap_read_x", 32'(read_x), 32'd0);
    chk("wrap_read_y", 32'(read_y), 32'd0);
    wait_fs();
    fs2 = cyc;
    chk("frame_period", 32'(fs2 - fs1), 32'(FRAME));
    chk("vsync_cycles", 32'(vs_cycles), 32'(6 * LINE));

    @(posedge clk);
    #2;
    white = 1'b0;
    wait_xy(400, 6);
    chk("pre_reset_rgb", 32'({video_red, video_green, video_blue}), 32'h008E_06A5);
    #2;
    rst_n = 1'b0;
    run   = 1'b0;
    sb_q.delete();
    #1;
    chk_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    release_and_check("rerel");

    wait_xy(5, 3);
    @(negedge clk);
    @(negedge clk);
    chk("rerel_pix_5_3", 32'({video_red, video_green, video_blue}), 32'h0005_03A5);

    run = 1'b0;
    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
